// File: rtl/input_buffer_b4_reader.sv
// rtl/input_buffer_b4_reader.sv - read sequencer for the 32-bank Input Buffer B4
// Issues lock-step bank reads, absorbs the 1-cycle RAM latency in a 2-entry FIFO, streams rows out.
module input_buffer_b4_reader #(
  parameter int NUM_BANK   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_DEPTH = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          start_addr,
  input  logic [ADDR_WIDTH-1:0]          rd_len,
  input  logic [NUM_BANK-1:0]            bank_mask,
  output logic [NUM_BANK-1:0]            rd_ena,
  output logic [NUM_BANK-1:0]            rd_wea,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] ram_dout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_BANK*DATA_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W = NUM_BANK * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] issued;
  logic [ADDR_WIDTH-1:0] next_issued;
  logic [NUM_BANK-1:0]   mask;
  logic                  inflight;
  logic                  inflight_last;

  logic [ROW_W-1:0]      fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  drain_done;
  logic [ROW_W-1:0]      lane_mask_row;

  assign out_valid   = (fifo_cnt != 2'd0);
  assign out_data    = fifo_data[rd_ptr];
  assign out_last    = out_valid & fifo_last[rd_ptr];
  assign pop         = out_valid & out_ready;
  assign push        = inflight;
  assign next_issued = issued + 1'b1;

  // A slot is free if the FIFO plus the in-flight read leave room, or the head leaves this cycle.
  assign issue = (state == READ) && (issued < len) &&
                 ((({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2) || pop);

  // Leave DRAIN on the edge that pops the final row so done lands in the very next cycle.
  assign drain_done = !inflight && ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && pop));

  assign rd_ena = issue ? mask : '0;
  assign rd_wea = '0;

  for (genvar i = 0; i < NUM_BANK; i++) begin : g_lane
    assign rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]      = addr;
    assign lane_mask_row[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask[i]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      len    <= '0;
      issued <= '0;
      mask   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rd_len != '0) begin
              addr   <= start_addr;
              len    <= rd_len;
              mask   <= bank_mask;
              issued <= '0;
              busy   <= 1'b1;
              state  <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            issued <= next_issued;
            addr   <= (addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr + 1'b1;
            if (next_issued == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (next_issued == len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= ram_dout & lane_mask_row;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt == 2'd2));

endmodule

// File: tb/tb_input_buffer_b4_reader.sv
// tb/tb_input_buffer_b4_reader.sv - directed bench for input_buffer_b4_reader
// Behavioural bank RAMs hold word a of bank i = {i, a, A5A5}; rows are checked lane by lane.
module tb_input_buffer_b4_reader;
  localparam int NB = 32;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     rd_len;
  logic [NB-1:0]     bank_mask;
  logic [NB-1:0]     rd_ena;
  logic [NB-1:0]     rd_wea;
  logic [NB*AW-1:0]  rd_addr;
  logic [NB*DW-1:0]  ram_dout;
  logic              out_valid;
  logic              out_ready;
  logic [NB*DW-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_buffer_b4_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .rd_len(rd_len),
    .bank_mask(bank_mask), .rd_ena(rd_ena), .rd_wea(rd_wea), .rd_addr(rd_addr),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [31:0] word(input int i, input int a);
    return {i[7:0], a[7:0], 16'hA5A5};
  endfunction

  // Disabled banks return junk so any use of an unrequested read shows up.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      ram_dout[i*DW +: DW] <= rd_ena[i] ? word(i, int'(rd_addr[i*AW +: AW])) : $urandom;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data0"}, out_data == '0, 1);
    check({tag, "_ena"}, rd_ena, 0);
    check({tag, "_wea"}, rd_wea, 0);
    check({tag, "_addr0"}, rd_addr == '0, 1);
  endtask

  // mode 0: ready always 1; mode 1: 1,0,0,1 pattern then random.
  task automatic run_cmd(input int sa, input int len, input logic [31:0] mask,
                         input int mode, input int abort_rows, input bit restart);
    int cyc = 0, hs = 0, issues = 0, done_cyc = -1, last_hs_cyc = -1;
    int first_issue = -1, first_valid = -1;
    logic [NB*DW-1:0] prev_data = '0, d;
    logic prev_stall = 1'b0, prev_last = 1'b0, v, l, r;
    @(negedge clk);
    start = 1'b1; start_addr = AW'(sa); rd_len = AW'(len); bank_mask = mask; out_ready = 1'b1;
    while (cyc < 200 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      start = restart && (cyc == 3);
      if (restart && cyc == 3) begin
        start_addr = 3'd0; rd_len = 3'd2; bank_mask = 32'h0;
      end
      v = out_valid; d = out_data; l = out_last;
      if (done) done_cyc = cyc;
      check("busy", busy, (len > 0) && (done_cyc < 0));
      if (v && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check("stall_valid", v, 1);
        check("stall_data", d == prev_data, 1);
        check("stall_last", l, prev_last);
      end
      if (mode == 0) r = 1'b1;
      else if (cyc < 12) r = (cyc % 4 == 1) || (cyc % 4 == 0);
      else r = 1'($urandom_range(0, 1));
      out_ready = r;
      #1;
      check("wea", rd_wea, 0);
      if (rd_ena != '0) begin
        if (first_issue < 0) first_issue = cyc;
        check("ena_mask", rd_ena, mask);
        for (int i = 0; i < NB; i++)
          if (rd_addr[i*AW +: AW] != rd_addr[AW-1:0]) check("addr_equal", i, -1);
        check("issue_addr", rd_addr[AW-1:0], (sa + issues) % DEPTH);
        check("credit", (issues - hs - ((v && r) ? 1 : 0) + 1) <= 2, 1);
        issues++;
      end
      if (v && r) begin
        if (abort_rows != 0 && hs == abort_rows) begin
          rst_n = 1'b0;
          #1;
          check_idle_outputs("midreset");
          @(negedge clk);
          rst_n = 1'b1;
          repeat (2) begin
            @(negedge clk);
            check("postreset_done", done, 0);
            check("postreset_busy", busy, 0);
          end
          return;
        end
        for (int i = 0; i < NB; i++)
          check($sformatf("row%0d_lane%0d", hs, i), d[i*DW +: DW],
                mask[i] ? word(i, (sa + hs) % DEPTH) : 32'h0);
        check($sformatf("row%0d_last", hs), l, hs == len - 1);
        hs++;
        last_hs_cyc = cyc;
      end
      prev_stall = v && !r; prev_data = d; prev_last = l;
    end
    start = 1'b0;
    check("done_seen", done_cyc > 0, 1);
    check("rows", hs, len);
    check("issues", issues, len);
    if (len == 0) check("zero_done_cyc", done_cyc, 1);
    else begin
      check("first_issue", first_issue, 1);
      check("done_cyc", done_cyc, last_hs_cyc + 1);
      if (mode == 0) begin
        check("first_valid", first_valid, 3);
        check("last_hs_cyc", last_hs_cyc, len + 2);
      end
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_done", done, 0);
      check("after_busy", busy, 0);
      check("after_ena", rd_ena, 0);
      check("after_valid", out_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; rd_len = '0; bank_mask = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    run_cmd(0, 7, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_cmd(5, 4, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_cmd(1, 7, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run_cmd(3, 6, 32'h0000_FFFF, 1, 0, 1'b0);
    run_cmd(0, 0, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_cmd(2, 5, 32'hFFFF_FFFF, 0, 0, 1'b1);
    run_cmd(4, 7, 32'hFFFF_FFFF, 0, 3, 1'b0);
    run_cmd(6, 3, 32'hF0F0_0F0F, 1, 0, 1'b0);
    run_cmd(6, 1, 32'h8000_0001, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end
endmodule
